sram_read_arbiter: RTL and testbench

Three-way arbiter that shares one downstream SRAM-style read port among the instruction cache (port 0), the data cache (port 1) and the LSU uncached path (port 2). It sits between those requesters and the read side of the memory bridge. It serialises requests with round-robin fairness, keeps one transaction outstanding and routes each 256-bit response back to its owner. A fetch abort (branch redirect) on port 0 drains the in-flight refill without delivering it.

---
 rtl/sram_bus_pkg.sv | 30 +++
 rtl/sram_read_arbiter_if.sv | 37 +++
 rtl/rr_pick3.sv | 56 +++++
 rtl/sram_read_arbiter.sv | 145 ++++++++++++++
 tb/tb_sram_read_arbiter.sv | 310 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sram_bus_pkg.sv
// Shared types and constants for the SRAM read-side arbiter, caches and interconnect.
package sram_bus_pkg;

  localparam int ADDR_W = 32;
  localparam int TYPE_W = 6;
  localparam int DATA_W = 256;

  localparam logic [1:0] PORT_I = 2'd0;
  localparam logic [1:0] PORT_D = 2'd1;
  localparam logic [1:0] PORT_U = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } state_t;

  function automatic logic [2:0] port_onehot(input logic [1:0] id);
    logic [2:0] oh;
    oh = 3'b000;
    case (id)
      PORT_I:  oh = 3'b001;
      PORT_D:  oh = 3'b010;
      PORT_U:  oh = 3'b100;
      default: oh = 3'b000;
    endcase
    return oh;
  endfunction

endpackage

// File: rtl/sram_read_arbiter_if.sv
// Requester, response and downstream signals of the SRAM read arbiter, bundled as one interface.
interface sram_read_arbiter_if #(
  parameter int ADDR_W = sram_bus_pkg::ADDR_W,
  parameter int TYPE_W = sram_bus_pkg::TYPE_W,
  parameter int DATA_W = sram_bus_pkg::DATA_W
);
  logic              r0_req,  r1_req,  r2_req;
  logic [ADDR_W-1:0] r0_addr, r1_addr, r2_addr;
  logic [TYPE_W-1:0] r0_type, r1_type, r2_type;
  logic              r0_rdy,  r1_rdy,  r2_rdy;
  logic [DATA_W-1:0] re0_data, re1_data, re2_data;
  logic              re0_valid, re1_valid, re2_valid;
  logic              abort_0;
  logic              m_req;
  logic [ADDR_W-1:0] m_addr;
  logic [TYPE_W-1:0] m_type;
  logic              m_rdy;
  logic [DATA_W-1:0] m_data;
  logic              m_valid;
  logic              busy;

  // Arbiter side.
  modport slave (
    input  r0_req, r1_req, r2_req, r0_addr, r1_addr, r2_addr,
           r0_type, r1_type, r2_type, abort_0, m_rdy, m_data, m_valid,
    output r0_rdy, r1_rdy, r2_rdy, re0_data, re1_data, re2_data,
           re0_valid, re1_valid, re2_valid, m_req, m_addr, m_type, busy
  );

  // Requester/memory side as seen by the surrounding system.
  modport master (
    output r0_req, r1_req, r2_req, r0_addr, r1_addr, r2_addr,
           r0_type, r1_type, r2_type, abort_0, m_rdy, m_data, m_valid,
    input  r0_rdy, r1_rdy, r2_rdy, re0_data, re1_data, re2_data,
           re0_valid, re1_valid, re2_valid, m_req, m_addr, m_type, busy
  );
endinterface

// File: rtl/rr_pick3.sv
// Combinational three-way round-robin selector; scanning starts at the port after `last`.
module rr_pick3
  import sram_bus_pkg::*;
(
  input  logic [2:0] req,
  input  logic [1:0] last,
  output logic [2:0] grant,
  output logic [1:0] id
);

  logic [1:0] first_s, second_s, third_s;

  // Priority order derived from the previous winner.
  always_comb begin
    first_s  = PORT_I;
    second_s = PORT_D;
    third_s  = PORT_U;
    case (last)
      PORT_I: begin
        first_s  = PORT_D;
        second_s = PORT_U;
        third_s  = PORT_I;
      end
      PORT_D: begin
        first_s  = PORT_U;
        second_s = PORT_I;
        third_s  = PORT_D;
      end
      default: begin
        first_s  = PORT_I;
        second_s = PORT_D;
        third_s  = PORT_U;
      end
    endcase
  end

  // First requesting port in that order wins.
  always_comb begin
    grant = 3'b000;
    id    = PORT_I;
    if (|(req & port_onehot(first_s))) begin
      id    = first_s;
      grant = port_onehot(first_s);
    end else if (|(req & port_onehot(second_s))) begin
      id    = second_s;
      grant = port_onehot(second_s);
    end else if (|(req & port_onehot(third_s))) begin
      id    = third_s;
      grant = port_onehot(third_s);
    end else begin
      id    = PORT_I;
      grant = 3'b000;
    end
  end

endmodule

// File: rtl/sram_read_arbiter.sv
// Round-robin arbiter sharing one SRAM read port among I-cache, D-cache and LSU,
// one transaction outstanding, with port-0 abort that drains the refill silently.
module sram_read_arbiter #(
  parameter int ADDR_W = sram_bus_pkg::ADDR_W,
  parameter int TYPE_W = sram_bus_pkg::TYPE_W,
  parameter int DATA_W = sram_bus_pkg::DATA_W
) (
  input  logic               clk,
  input  logic               rst,
  sram_read_arbiter_if.slave bus
);
  import sram_bus_pkg::*;

  state_t            state_q, state_d;
  logic [1:0]        last_q, last_d;
  logic [1:0]        port_q, port_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [TYPE_W-1:0] type_q, type_d;
  logic              drop_q, drop_d;

  logic [2:0]        req_s, grant_s, rdy_s, valid_s;
  logic [1:0]        pick_id_s;
  logic              abort_hit_s;
  logic              m_req_s;

  assign req_s       = {bus.r2_req, bus.r1_req, bus.r0_req};
  assign abort_hit_s = bus.abort_0 && (port_q == PORT_I);

  rr_pick3 u_pick (
    .req   (req_s),
    .last  (last_q),
    .grant (grant_s),
    .id    (pick_id_s)
  );

  // Next-state, latch updates and handshake outputs.
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    port_d  = port_q;
    addr_d  = addr_q;
    type_d  = type_q;
    drop_d  = drop_q;
    rdy_s   = 3'b000;
    valid_s = 3'b000;
    m_req_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        drop_d = 1'b0;
        if (grant_s != 3'b000) begin
          rdy_s   = grant_s;
          port_d  = pick_id_s;
          last_d  = pick_id_s;
          state_d = ST_ISSUE;
          case (pick_id_s)
            PORT_I: begin
              addr_d = bus.r0_addr;
              type_d = bus.r0_type;
            end
            PORT_D: begin
              addr_d = bus.r1_addr;
              type_d = bus.r1_type;
            end
            default: begin
              addr_d = bus.r2_addr;
              type_d = bus.r2_type;
            end
          endcase
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        m_req_s = 1'b1;
        if (abort_hit_s) begin
          drop_d = 1'b1;
        end else begin
          drop_d = drop_q;
        end
        if (bus.m_rdy) begin
          state_d = ST_WAIT;
        end else begin
          state_d = ST_ISSUE;
        end
      end
      ST_WAIT: begin
        if (abort_hit_s) begin
          drop_d = 1'b1;
        end else begin
          drop_d = drop_q;
        end
        if (bus.m_valid) begin
          // A same-cycle abort must already suppress this response.
          if (drop_q || abort_hit_s) begin
            valid_s = 3'b000;
          end else begin
            valid_s = port_onehot(port_q);
          end
          drop_d  = 1'b0;
          state_d = ST_IDLE;
        end else begin
          state_d = ST_WAIT;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and request latch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      last_q  <= PORT_U;
      port_q  <= PORT_I;
      addr_q  <= {ADDR_W{1'b0}};
      type_q  <= {TYPE_W{1'b0}};
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      port_q  <= port_d;
      addr_q  <= addr_d;
      type_q  <= type_d;
      drop_q  <= drop_d;
    end
  end

  // rdy is combinational from the requests, so hold it low while reset is asserted.
  assign bus.r0_rdy    = rdy_s[0] & ~rst;
  assign bus.r1_rdy    = rdy_s[1] & ~rst;
  assign bus.r2_rdy    = rdy_s[2] & ~rst;
  assign bus.re0_valid = valid_s[0];
  assign bus.re1_valid = valid_s[1];
  assign bus.re2_valid = valid_s[2];
  assign bus.re0_data  = bus.m_data;
  assign bus.re1_data  = bus.m_data;
  assign bus.re2_data  = bus.m_data;
  assign bus.m_req     = m_req_s;
  assign bus.m_addr    = addr_q;
  assign bus.m_type    = type_q;
  assign bus.busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_sram_read_arbiter.sv
// Directed self-checking bench for sram_read_arbiter.
module tb_sram_read_arbiter;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  sram_read_arbiter_if bus ();

  sram_read_arbiter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.r0_req  = 1'b0;
    bus.r1_req  = 1'b0;
    bus.r2_req  = 1'b0;
    bus.r0_addr = 32'h0;
    bus.r1_addr = 32'h0;
    bus.r2_addr = 32'h0;
    bus.r0_type = 6'h0;
    bus.r1_type = 6'h0;
    bus.r2_type = 6'h0;
    bus.abort_0 = 1'b0;
    bus.m_rdy   = 1'b0;
    bus.m_valid = 1'b0;
    bus.m_data  = 256'h0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_inputs();
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    clear_inputs();
    bus.r0_req = 1'b1;
    bus.r1_req = 1'b1;
    bus.r2_req = 1'b1;
    step();
    checks++;
    if ({bus.r0_rdy, bus.r1_rdy, bus.r2_rdy} !== 3'b000) begin
      $display("FAIL reset_rdy: got %b want 000", {bus.r0_rdy, bus.r1_rdy, bus.r2_rdy}); errors++;
    end
    checks++;
    if ({bus.m_req, bus.busy, bus.re0_valid, bus.re1_valid, bus.re2_valid} !== 5'b00000) begin
      $display("FAIL reset_ctrl: got %b want 00000",
               {bus.m_req, bus.busy, bus.re0_valid, bus.re1_valid, bus.re2_valid}); errors++;
    end
    checks++;
    if (bus.m_addr !== 32'h0 || bus.m_type !== 6'h0) begin
      $display("FAIL reset_fields: got %h/%h want 0/0", bus.m_addr, bus.m_type); errors++;
    end
    rst = 1'b0;
    #1;
    checks++;
    if ({bus.r2_rdy, bus.r1_rdy, bus.r0_rdy} !== 3'b001) begin
      $display("FAIL reset_first_winner: got %b want 001", {bus.r2_rdy, bus.r1_rdy, bus.r0_rdy}); errors++;
    end
    clear_inputs();
  endtask

  task automatic test_single();
    logic [255:0] pat;
    pat = {32{8'hA5}};
    do_reset();
    bus.r1_req  = 1'b1;
    bus.r1_addr = 32'h8000_0040;
    bus.r1_type = 6'h05;
    #1;
    checks++;
    if ({bus.r2_rdy, bus.r1_rdy, bus.r0_rdy} !== 3'b010) begin
      $display("FAIL single_rdy: got %b want 010", {bus.r2_rdy, bus.r1_rdy, bus.r0_rdy}); errors++;
    end
    step();
    bus.r1_req = 1'b0;
    for (int c = 0; c < 2; c++) begin
      if (c == 1) bus.m_rdy = 1'b1;
      #1;
      checks++;
      if (bus.m_req !== 1'b1 || bus.m_addr !== 32'h8000_0040 || bus.m_type !== 6'h05) begin
        $display("FAIL single_issue: got req=%b addr=%h type=%h want 1/80000040/05",
                 bus.m_req, bus.m_addr, bus.m_type); errors++;
      end
      step();
    end
    bus.m_rdy = 1'b0;
    for (int c = 0; c < 2; c++) begin
      #1;
      checks++;
      if (bus.m_req !== 1'b0 || bus.re1_valid !== 1'b0 || bus.busy !== 1'b1) begin
        $display("FAIL single_wait: got req=%b v1=%b busy=%b want 0/0/1",
                 bus.m_req, bus.re1_valid, bus.busy); errors++;
      end
      step();
    end
    bus.m_valid = 1'b1;
    bus.m_data  = pat;
    #1;
    checks++;
    if ({bus.re2_valid, bus.re1_valid, bus.re0_valid} !== 3'b010 || bus.re1_data !== pat) begin
      $display("FAIL single_resp: got v=%b data=%h want 010/%h",
               {bus.re2_valid, bus.re1_valid, bus.re0_valid}, bus.re1_data, pat); errors++;
    end
    step();
    bus.m_valid = 1'b0;
    #1;
    checks++;
    if (bus.re1_valid !== 1'b0 || bus.busy !== 1'b0) begin
      $display("FAIL single_after: got v1=%b busy=%b want 0/0", bus.re1_valid, bus.busy); errors++;
    end
  endtask

  task automatic test_fairness();
    int n;
    logic [2:0] rdy;
    logic [2:0] want;
    do_reset();
    bus.r0_req = 1'b1; bus.r1_req = 1'b1; bus.r2_req = 1'b1;
    bus.m_rdy  = 1'b1; bus.m_valid = 1'b1;
    n = 0;
    for (int c = 0; c < 40 && n < 6; c++) begin
      #1;
      rdy = {bus.r2_rdy, bus.r1_rdy, bus.r0_rdy};
      checks++;
      if ($countones(rdy) > 1) begin
        $display("FAIL fair_overlap: got %b want at most one", rdy); errors++;
      end
      if (rdy != 3'b000) begin
        want = 3'b001 << (n % 3);
        checks++;
        if (rdy !== want) begin
          $display("FAIL fair_order: grant %0d got %b want %b", n, rdy, want); errors++;
        end
        n++;
      end
      step();
    end
    checks++;
    if (n != 6) begin
      $display("FAIL fair_count: got %0d grants want 6", n); errors++;
    end
    clear_inputs();
  endtask

  // Runs one port-0 transaction; abort_mode 0=none, 1=during WAIT, 2=with m_valid, 3=in IDLE.
  task automatic port0_txn(input int abort_mode, input logic want_valid, input string name);
    bus.r0_req  = 1'b1;
    bus.abort_0 = (abort_mode == 3);
    #1;
    checks++;
    if (bus.r0_rdy !== 1'b1) begin
      $display("FAIL %s_rdy: got %b want 1", name, bus.r0_rdy); errors++;
    end
    step();
    bus.r0_req  = 1'b0;
    bus.abort_0 = 1'b0;
    bus.m_rdy   = 1'b1;
    step();
    bus.m_rdy   = 1'b0;
    bus.abort_0 = (abort_mode == 1);
    step();
    bus.abort_0 = (abort_mode == 2);
    bus.m_valid = 1'b1;
    bus.m_data  = 256'h1234;
    #1;
    checks++;
    if ({bus.re2_valid, bus.re1_valid, bus.re0_valid} !== {2'b00, want_valid}) begin
      $display("FAIL %s_valid: got %b want %b", name,
               {bus.re2_valid, bus.re1_valid, bus.re0_valid}, {2'b00, want_valid}); errors++;
    end
    step();
    bus.m_valid = 1'b0;
    bus.abort_0 = 1'b0;
    #1;
    checks++;
    if (bus.busy !== 1'b0) begin
      $display("FAIL %s_busy: got %b want 0", name, bus.busy); errors++;
    end
  endtask

  task automatic test_abort();
    do_reset();
    port0_txn(1, 1'b0, "abort_wait");
    bus.r2_req = 1'b1;
    #1;
    checks++;
    if ({bus.r2_rdy, bus.r1_rdy, bus.r0_rdy} !== 3'b100) begin
      $display("FAIL abort_next_rdy: got %b want 100", {bus.r2_rdy, bus.r1_rdy, bus.r0_rdy}); errors++;
    end
    step();
    bus.r2_req = 1'b0;
    bus.m_rdy  = 1'b1;
    step();
    bus.m_rdy   = 1'b0;
    bus.m_valid = 1'b1;
    #1;
    checks++;
    if ({bus.re2_valid, bus.re1_valid, bus.re0_valid} !== 3'b100) begin
      $display("FAIL abort_next_resp: got %b want 100",
               {bus.re2_valid, bus.re1_valid, bus.re0_valid}); errors++;
    end
    step();
    bus.m_valid = 1'b0;
    port0_txn(2, 1'b0, "abort_coinc");
    port0_txn(3, 1'b1, "abort_idle");
    port0_txn(0, 1'b1, "abort_clear");
  endtask

  task automatic test_reset_mid();
    do_reset();
    bus.r1_req = 1'b1;
    step();
    bus.r1_req = 1'b0;
    #1;
    checks++;
    if (bus.m_req !== 1'b1) begin
      $display("FAIL rstmid_issue: got %b want 1", bus.m_req); errors++;
    end
    rst = 1'b1;
    #1;
    checks++;
    if (bus.m_req !== 1'b0 || bus.busy !== 1'b0 || bus.m_addr !== 32'h0) begin
      $display("FAIL rstmid_async: got req=%b busy=%b addr=%h want 0/0/0",
               bus.m_req, bus.busy, bus.m_addr); errors++;
    end
    step();
    rst = 1'b0;
    bus.m_valid = 1'b1;
    #1;
    checks++;
    if ({bus.re2_valid, bus.re1_valid, bus.re0_valid, bus.busy} !== 4'b0000) begin
      $display("FAIL rstmid_stray: got %b want 0000",
               {bus.re2_valid, bus.re1_valid, bus.re0_valid, bus.busy}); errors++;
    end
    step();
    bus.m_valid = 1'b0;
  endtask

  task automatic test_backpressure();
    do_reset();
    bus.r0_req  = 1'b1;
    bus.r0_addr = 32'hDEAD_BEE0;
    bus.r0_type = 6'h2A;
    step();
    bus.r0_req  = 1'b0;
    bus.r0_addr = 32'h0;
    bus.r1_req  = 1'b1;
    bus.r2_req  = 1'b1;
    for (int c = 0; c < 10; c++) begin
      #1;
      checks++;
      if (bus.m_req !== 1'b1 || bus.m_addr !== 32'hDEAD_BEE0 || bus.m_type !== 6'h2A ||
          {bus.r2_rdy, bus.r1_rdy, bus.r0_rdy} !== 3'b000) begin
        $display("FAIL bp_hold: cycle %0d got req=%b addr=%h type=%h rdy=%b want 1/deadbee0/2a/000",
                 c, bus.m_req, bus.m_addr, bus.m_type, {bus.r2_rdy, bus.r1_rdy, bus.r0_rdy}); errors++;
      end
      step();
    end
    bus.m_rdy = 1'b1;
    step();
    bus.m_rdy   = 1'b0;
    bus.m_valid = 1'b1;
    #1;
    checks++;
    if ({bus.r2_rdy, bus.r1_rdy, bus.r0_rdy} !== 3'b000 || bus.re0_valid !== 1'b1) begin
      $display("FAIL bp_done: got rdy=%b v0=%b want 000/1",
               {bus.r2_rdy, bus.r1_rdy, bus.r0_rdy}, bus.re0_valid); errors++;
    end
    step();
    bus.m_valid = 1'b0;
    #1;
    checks++;
    if ({bus.r2_rdy, bus.r1_rdy, bus.r0_rdy} !== 3'b010) begin
      $display("FAIL bp_next: got %b want 010", {bus.r2_rdy, bus.r1_rdy, bus.r0_rdy}); errors++;
    end
    step();
    clear_inputs();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b1;
    clear_inputs();
    test_reset();
    test_single();
    test_fairness();
    test_abort();
    test_reset_mid();
    test_backpressure();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
